// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus of the register scoreboard.
// master: decode/writeback side (drives requests, observes stall/pend/err_unf)
// slave : scoreboard side
interface reg_scoreboard_if;
  logic       iss_valid;
  logic [2:0] iss_rs;
  logic [2:0] iss_rt;
  logic       iss_rs_en;
  logic       iss_rt_en;
  logic [2:0] iss_rd;
  logic       iss_rd_en;
  logic       iss_stall;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       flush;
  logic [7:0] pend;
  logic       err_unf;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_rs_en, iss_rt_en, iss_rd, iss_rd_en,
    output wb_valid, wb_rd, flush,
    input  iss_stall, pend, err_unf
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_rs_en, iss_rt_en, iss_rd, iss_rd_en,
    input  wb_valid, wb_rd, flush,
    output iss_stall, pend, err_unf
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters for 8 registers.
// Blocks issue on RAW hazards (source pending) and on counter saturation of the
// destination; writebacks retire one outstanding write each.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - reg_scoreboard_if.slave: issue request, writeback, flush,
//          iss_stall (combinational), pend (registered), err_unf (sticky)
// Optional feature: define SCB_WB_BYPASS_EN to let a source whose last
// outstanding write retires in the same cycle issue without stalling.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave bus
);

  localparam int unsigned NREG = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;
  logic             err_q;
  logic             err_d;
  logic             rs_busy;
  logic             rt_busy;
  logic             rd_full;
  logic             stall;
  logic             accept;
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;

  // Hazard detection against registered counts
  always_comb begin
    rs_busy = bus.iss_rs_en && (cnt_q[bus.iss_rs] != '0);
    rt_busy = bus.iss_rt_en && (cnt_q[bus.iss_rt] != '0);
`ifdef SCB_WB_BYPASS_EN
    // last outstanding write to the source retires this cycle
    if (bus.wb_valid && (bus.wb_rd == bus.iss_rs) && (cnt_q[bus.iss_rs] == CNT_ONE))
      rs_busy = 1'b0;
    if (bus.wb_valid && (bus.wb_rd == bus.iss_rt) && (cnt_q[bus.iss_rt] == CNT_ONE))
      rt_busy = 1'b0;
`endif
    rd_full = bus.iss_rd_en && (cnt_q[bus.iss_rd] == CNT_MAX);
    stall   = bus.iss_valid && (rs_busy || rt_busy || rd_full);
    accept  = bus.iss_valid && !stall;
  end

  // One-hot increment/decrement requests
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (accept && bus.iss_rd_en) inc_v[bus.iss_rd] = 1'b1;
    if (bus.wb_valid)            dec_v[bus.wb_rd]  = 1'b1;
  end

  // Next counts; same-register inc+dec cancels, flush overrides everything
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
        else                err_d    = 1'b1;
      end
      if (bus.flush) cnt_d[i] = '0;
      pend_d[i] = (cnt_d[i] != '0);
    end
    if (bus.flush) err_d = err_q;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign bus.iss_stall = stall;
  assign bus.pend      = pend_q;
  assign bus.err_unf   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (CNT_W = 2): directed vector table,
// hand-written corner sequences, then random traffic against a counter model.
module tb_reg_scoreboard;

  typedef struct {
    logic       v;
    logic [2:0] rs;
    logic       rs_en;
    logic [2:0] rt;
    logic       rt_en;
    logic [2:0] rd;
    logic       rd_en;
    logic       wbv;
    logic [2:0] wbrd;
    logic       fl;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       e_stall;
    logic [7:0] e_pend;
    logic       e_err;
  } vec_t;

  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if bus ();
  reg_scoreboard #(.CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int m_cnt [8];
  bit m_err;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t st(bit v, int rs, bit rse, int rt, bit rte,
                               int rd, bit rde, bit wbv, int wbrd, bit fl);
    stim_t s;
    s.v = v; s.rs = 3'(rs); s.rs_en = rse; s.rt = 3'(rt); s.rt_en = rte;
    s.rd = 3'(rd); s.rd_en = rde; s.wbv = wbv; s.wbrd = 3'(wbrd); s.fl = fl;
    return s;
  endfunction

  // Reference model: plain integer counters
  function automatic bit m_src_busy(int r, stim_t s);
    if (m_cnt[r] == 0) return 1'b0;
`ifdef SCB_WB_BYPASS_EN
    if (s.wbv && int'(s.wbrd) == r && m_cnt[r] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_stall(stim_t s);
    if (!s.v) return 1'b0;
    if (s.rs_en && m_src_busy(int'(s.rs), s)) return 1'b1;
    if (s.rt_en && m_src_busy(int'(s.rt), s)) return 1'b1;
    if (s.rd_en && m_cnt[s.rd] == MAXC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_step(stim_t s, bit stalled);
    bit incr;
    if (s.fl) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      return;
    end
    incr = s.v && !stalled && s.rd_en;
    if (incr && s.wbv && s.rd == s.wbrd) return;
    if (s.wbv) begin
      if (m_cnt[s.wbrd] > 0) m_cnt[s.wbrd]--;
      else                   m_err = 1'b1;
    end
    if (incr) m_cnt[s.rd]++;
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_err = 1'b0;
  endfunction

  task automatic drive(input stim_t s);
    bus.iss_valid = s.v;   bus.iss_rs = s.rs;     bus.iss_rs_en = s.rs_en;
    bus.iss_rt    = s.rt;  bus.iss_rt_en = s.rt_en;
    bus.iss_rd    = s.rd;  bus.iss_rd_en = s.rd_en;
    bus.wb_valid  = s.wbv; bus.wb_rd = s.wbrd;    bus.flush = s.fl;
  endtask

  // One clock: called at negedge; checks stall before the edge, pend/err after
  task automatic cycle(input stim_t s, output logic stall_o,
                       output logic [7:0] pend_o, output logic err_o);
    bit es;
    drive(s);
    #1;
    es = m_stall(s);
    stall_o = bus.iss_stall;
    chk("stall_model", 8'(stall_o), 8'(es));
    @(posedge clk);
    m_step(s, es);
    @(negedge clk);
    pend_o = bus.pend;
    err_o  = bus.err_unf;
    chk("pend_model", pend_o, m_pend());
    chk("err_model", 8'(err_o), 8'(m_err));
  endtask

  task automatic do_reset();
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t       tbl [$];
  logic       so;
  logic [7:0] po;
  logic       eo;
  stim_t      rs_s;
  stim_t      idle;

  initial begin
    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Directed table, applied from reset
    tbl.push_back('{st(1,0,0,0,0,3,1,0,0,0), 1'b0, 8'h08, 1'b0}); // issue rd3
    tbl.push_back('{st(1,3,1,0,0,0,0,0,0,0), 1'b1, 8'h08, 1'b0}); // rs3 hazard
    tbl.push_back('{st(1,0,0,3,1,2,1,0,0,0), 1'b1, 8'h08, 1'b0}); // rt3 hazard, rd2 not counted
    tbl.push_back('{st(0,0,0,0,0,0,0,1,3,0), 1'b0, 8'h00, 1'b0}); // retire rd3
    tbl.push_back('{st(1,0,0,0,0,5,1,0,0,0), 1'b0, 8'h20, 1'b0}); // rd5 #1
    tbl.push_back('{st(1,0,0,0,0,5,1,0,0,0), 1'b0, 8'h20, 1'b0}); // rd5 #2
    tbl.push_back('{st(1,0,0,0,0,5,1,0,0,0), 1'b0, 8'h20, 1'b0}); // rd5 #3 (saturated)
    tbl.push_back('{st(1,0,0,0,0,5,1,0,0,0), 1'b1, 8'h20, 1'b0}); // rd5 #4 stalls
    tbl.push_back('{st(1,0,0,0,0,5,1,1,5,0), 1'b1, 8'h20, 1'b0}); // still stalled, wb5 -> 2
    tbl.push_back('{st(1,0,0,0,0,5,1,0,0,0), 1'b0, 8'h20, 1'b0}); // rd5 #4 accepted -> 3
    tbl.push_back('{st(0,0,0,0,0,0,0,1,5,0), 1'b0, 8'h20, 1'b0});
    tbl.push_back('{st(0,0,0,0,0,0,0,1,5,0), 1'b0, 8'h20, 1'b0});
    tbl.push_back('{st(0,0,0,0,0,0,0,1,5,0), 1'b0, 8'h00, 1'b0});
    tbl.push_back('{st(1,0,0,0,0,4,1,0,0,0), 1'b0, 8'h10, 1'b0}); // count4=1
    tbl.push_back('{st(1,0,0,0,0,4,1,1,4,0), 1'b0, 8'h10, 1'b0}); // inc+wb same reg
    tbl.push_back('{st(0,0,0,0,0,0,0,1,4,0), 1'b0, 8'h00, 1'b0});
    tbl.push_back('{st(0,0,0,0,0,0,0,1,6,0), 1'b0, 8'h00, 1'b1}); // underflow
    tbl.push_back('{st(0,0,0,0,0,0,0,0,0,0), 1'b0, 8'h00, 1'b1}); // sticky
    tbl.push_back('{st(0,0,0,0,0,0,0,0,0,1), 1'b0, 8'h00, 1'b1}); // flush keeps err
    tbl.push_back('{st(1,0,0,0,0,1,1,0,0,0), 1'b0, 8'h02, 1'b1});
    tbl.push_back('{st(1,0,0,0,0,1,1,0,0,0), 1'b0, 8'h02, 1'b1}); // count1=2
    tbl.push_back('{st(1,0,0,0,0,7,1,0,0,0), 1'b0, 8'h82, 1'b1}); // count7=1
    tbl.push_back('{st(1,0,0,0,0,1,1,0,0,1), 1'b0, 8'h00, 1'b1}); // flush beats issue
    tbl.push_back('{st(1,1,1,7,1,0,0,0,0,0), 1'b0, 8'h00, 1'b1}); // sources free after flush

    // Reset state, including stall evaluation while rst is held
    rst = 1'b1;
    m_reset();
    drive(st(1, 3, 1, 5, 1, 2, 1, 0, 0, 0));
    #2;
    chk("rst_stall", 8'(bus.iss_stall), 8'h00);
    chk("rst_pend", bus.pend, 8'h00);
    chk("rst_err", 8'(bus.err_unf), 8'h00);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].s, so, po, eo);
      chk($sformatf("vec%0d_stall", i), 8'(so), 8'(tbl[i].e_stall));
      chk($sformatf("vec%0d_pend", i), po, tbl[i].e_pend);
      chk($sformatf("vec%0d_err", i), 8'(eo), 8'(tbl[i].e_err));
    end

    // Source hit on a register whose only write retires the same cycle
    do_reset();
    cycle(st(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), so, po, eo);
    cycle(st(1, 2, 1, 0, 0, 0, 0, 1, 2, 0), so, po, eo);
`ifdef SCB_WB_BYPASS_EN
    chk("byp_stall", 8'(so), 8'h00);
`else
    chk("byp_stall", 8'(so), 8'h01);
`endif
    chk("byp_pend", po, 8'h00);
    cycle(st(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), so, po, eo);
    chk("byp_retry_stall", 8'(so), 8'h00);

    // Async reset mid-cycle discards outstanding writes and clears err_unf
    cycle(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), so, po, eo); // underflow sets err
    cycle(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0), so, po, eo);
    cycle(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0), so, po, eo);
    cycle(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0), so, po, eo);
    chk("pre_rst_pend", po, 8'h82);
    chk("pre_rst_err", 8'(eo), 8'h01);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst_pend", bus.pend, 8'h00);
    chk("async_rst_err", 8'(bus.err_unf), 8'h00);
    rs_s = st(1, 1, 1, 7, 1, 1, 1, 0, 0, 0);
    drive(rs_s);
    #1;
    chk("rst_held_stall", 8'(bus.iss_stall), 8'h00);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    cycle(st(0, 0, 0, 0, 0, 0, 0, 1, 7, 0), so, po, eo);
    chk("post_rst_wb_err", 8'(eo), 8'h01);

    // Random traffic against the model; writebacks mostly aim at pending regs
    do_reset();
    for (int n = 0; n < 600; n++) begin
      stim_t s;
      s.v     = ($urandom_range(3) != 0);
      s.rs    = 3'($urandom_range(7));
      s.rs_en = ($urandom_range(2) == 0);
      s.rt    = 3'($urandom_range(7));
      s.rt_en = ($urandom_range(3) == 0);
      s.rd    = 3'($urandom_range(7));
      s.rd_en = ($urandom_range(3) != 0);
      s.wbv   = ($urandom_range(1) == 1);
      s.wbrd  = 3'($urandom_range(7));
      if ($urandom_range(7) != 0) begin
        for (int k = 0; k < 8; k++) begin
          int r;
          r = int'($urandom_range(7));
          if (m_cnt[r] != 0) begin
            s.wbrd = 3'(r);
            break;
          end
        end
      end
      s.fl = ($urandom_range(59) == 0);
      cycle(s, so, po, eo);
      if (n == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
